retry_scheduler: RTL and testbench

- Issue-side controller for a retried (pipelined) datapath.
- Allocates a unique ID to every new operation and keeps a copy of its data in an ID-indexed table.
- Re-injects the stored operation when the end side requests a retry, and frees the ID on completion.
- Enforces a per-ID retry budget and reports operations that exceed it; sits directly in front of the protected pipeline.

---
 rtl/retry_scheduler.sv | 170 +++++++++++++++++
 tb/tb_retry_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retry_scheduler.sv
// retry_scheduler: issue-side controller for a retried pipeline.
// It hands out IDs to new operations and keeps a copy of each payload.
// It re-issues a stored payload when the end side asks for a retry.
// It frees the entry when the operation completes.
// It abandons an operation, with a one-cycle fail pulse, once its retry budget is spent.
// Optional statistics counters are compiled in with `define RETRY_SCHEDULER_STATS_EN.
module retry_scheduler #(
  parameter type DataType   = logic,
  parameter int  IDSize     = 2,
  parameter int  MaxRetries = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  DataType                data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [IDSize-1:0]      retry_id_i,
  input  logic                   retry_valid_i,
  output logic                   retry_ready_o,
  input  logic [IDSize-1:0]      done_id_i,
  input  logic                   done_valid_i,
  output DataType                data_o,
  output logic [IDSize-1:0]      id_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   fail_valid_o,
  output logic [IDSize-1:0]      fail_id_o,
`ifdef RETRY_SCHEDULER_STATS_EN
  input  logic                   stat_clear_i,
  output logic [31:0]            stat_retries_o,
  output logic [31:0]            stat_fails_o,
`endif
  output logic [(2**IDSize)-1:0] busy_o
);

  localparam int NumIds = 2 ** IDSize;
  localparam int CntW   = $clog2(MaxRetries + 1);

  // Per-entry state
  logic [NumIds-1:0] busy_reg;
  logic [CntW-1:0]   cnt_reg [NumIds];
  DataType           table_mem [NumIds];

  logic              fail_valid_reg;
  logic [IDSize-1:0] fail_id_reg;

  // Decoded events for this cycle
  logic [IDSize-1:0] free_id;
  logic              any_free;
  logic              done_hit;
  logic              retry_live;
  logic              retry_at_limit;
  logic              retry_issue;
  logic              retry_exhaust;
  logic              retry_hs;
  logic              new_hs;
  logic [NumIds-1:0] alloc_vec;
  logic [NumIds-1:0] free_vec;
  logic [NumIds-1:0] bump_vec;

  // Lowest-index idle entry; scanning downwards lets the lowest index win.
  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_id  = IDSize'(i);
        any_free = 1'b1;
      end
    end
  end

  // A completion on the same live ID swallows a retry request.
  // That ID is delivered, so re-sending it would duplicate the operation.
  assign done_hit       = done_valid_i & busy_reg[done_id_i];
  assign retry_live     = retry_valid_i & busy_reg[retry_id_i]
                          & ~(done_hit & (done_id_i == retry_id_i));
  assign retry_at_limit = (cnt_reg[retry_id_i] >= CntW'(MaxRetries));
  assign retry_issue    = retry_live & ~retry_at_limit;
  assign retry_exhaust  = retry_live & retry_at_limit;
  assign retry_hs       = retry_issue & ready_i;
  assign new_hs         = ~retry_valid_i & valid_i & ready_i & any_free;

  for (genvar gi = 0; gi < NumIds; gi++) begin : g_entry
    assign alloc_vec[gi] = new_hs & (free_id == IDSize'(gi));
    assign free_vec[gi]  = (done_hit & (done_id_i == IDSize'(gi)))
                         | (retry_exhaust & (retry_id_i == IDSize'(gi)));
    assign bump_vec[gi]  = retry_hs & (retry_id_i == IDSize'(gi));
  end

  // Issue mux: any retry request owns the cycle, even one that issues nothing.
  always_comb begin
    data_o        = data_i;
    id_o          = free_id;
    valid_o       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;
    if (retry_valid_i) begin
      data_o        = table_mem[retry_id_i];
      id_o          = retry_id_i;
      valid_o       = retry_issue;
      retry_ready_o = retry_issue ? ready_i : 1'b1;
    end else begin
      valid_o = valid_i & any_free;
      ready_o = ready_i & any_free;
    end
  end

  // Busy bits and retry counters; freeing and allocating never target the same entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_reg <= '0;
      for (int i = 0; i < NumIds; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (free_vec[i]) begin
          busy_reg[i] <= 1'b0;
          cnt_reg[i]  <= '0;
        end else if (alloc_vec[i]) begin
          busy_reg[i] <= 1'b1;
          cnt_reg[i]  <= '0;
        end else if (bump_vec[i]) begin
          cnt_reg[i]  <= cnt_reg[i] + 1'b1;
        end
      end
    end
  end

  // Payload table; written only when a new operation is accepted, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIds; i++) begin
      if (alloc_vec[i]) table_mem[i] <= data_i;
    end
  end

  // One-cycle fail pulse for the entry that ran out of retries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fail_valid_reg <= 1'b0;
      fail_id_reg    <= '0;
    end else begin
      fail_valid_reg <= retry_exhaust;
      if (retry_exhaust) fail_id_reg <= retry_id_i;
    end
  end

  assign fail_valid_o = fail_valid_reg;
  assign fail_id_o    = fail_id_reg;
  assign busy_o       = busy_reg;

`ifdef RETRY_SCHEDULER_STATS_EN
  logic [31:0] stat_retries_reg;
  logic [31:0] stat_fails_reg;

  // Saturating counters of retry handshakes and fail pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clear_i) begin
      stat_retries_reg <= '0;
      stat_fails_reg   <= '0;
    end else begin
      if (retry_hs && !(&stat_retries_reg))     stat_retries_reg <= stat_retries_reg + 32'd1;
      if (fail_valid_reg && !(&stat_fails_reg)) stat_fails_reg   <= stat_fails_reg + 32'd1;
    end
  end

  assign stat_retries_o = stat_retries_reg;
  assign stat_fails_o   = stat_fails_reg;
`endif

endmodule

// File: tb/tb_retry_scheduler.sv
// Bench for retry_scheduler (IDSize = 2, MaxRetries = 3, 8-bit payload).
// A spec-level model predicts every output each cycle.
// Directed literal checks pin the walkthrough scenarios.
module tb_retry_scheduler;

  typedef logic [7:0] data_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  data_t      data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [1:0] retry_id_i = '0;
  logic       retry_valid_i = 1'b0;
  logic       retry_ready_o;
  logic [1:0] done_id_i = '0;
  logic       done_valid_i = 1'b0;
  data_t      data_o;
  logic [1:0] id_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       fail_valid_o;
  logic [1:0] fail_id_o;
  logic [3:0] busy_o;
`ifdef RETRY_SCHEDULER_STATS_EN
  logic        stat_clear_i = 1'b0;
  logic [31:0] stat_retries_o;
  logic [31:0] stat_fails_o;
`endif

  retry_scheduler #(.DataType(data_t), .IDSize(2), .MaxRetries(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .retry_id_i(retry_id_i), .retry_valid_i(retry_valid_i), .retry_ready_o(retry_ready_o),
    .done_id_i(done_id_i), .done_valid_i(done_valid_i),
    .data_o(data_o), .id_o(id_o), .valid_o(valid_o), .ready_i(ready_i),
    .fail_valid_o(fail_valid_o), .fail_id_o(fail_id_o),
`ifdef RETRY_SCHEDULER_STATS_EN
    .stat_clear_i(stat_clear_i), .stat_retries_o(stat_retries_o), .stat_fails_o(stat_fails_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_busy [4];
  int         m_cnt  [4];
  data_t      m_data [4];
  bit         m_fail;
  logic [1:0] m_fail_id;

  typedef struct packed {
    logic       valid;
    logic       ready;
    logic       rready;
    data_t      data;
    logic [1:0] id;
    logic       retry_hs;
    logic       exhaust;
    logic       new_hs;
    logic       done_free;
  } exp_t;

  function automatic exp_t predict();
    exp_t e;
    int   free;
    bit   done_ok;
    e = '0;
    done_ok = done_valid_i && m_busy[done_id_i];
    if (retry_valid_i) begin
      e.rready = 1'b1;
      if (m_busy[retry_id_i] && !(done_ok && done_id_i == retry_id_i)) begin
        if (m_cnt[retry_id_i] < 3) begin
          e.valid    = 1'b1;
          e.data     = m_data[retry_id_i];
          e.id       = retry_id_i;
          e.rready   = ready_i;
          e.retry_hs = ready_i;
        end else begin
          e.exhaust = 1'b1;
        end
      end
    end else begin
      free = -1;
      for (int i = 0; i < 4; i++) if (!m_busy[i] && free < 0) free = i;
      if (free >= 0) begin
        e.valid  = valid_i;
        e.ready  = ready_i;
        e.data   = data_i;
        e.id     = 2'(free);
        e.new_hs = valid_i && ready_i;
      end
    end
    e.done_free = done_ok;
    return e;
  endfunction

  function automatic logic [3:0] model_busy();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance the model on every rising edge using the inputs held across it.
  always @(posedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0;
        m_cnt[i]  = 0;
      end
      m_fail    = 0;
      m_fail_id = '0;
    end else begin
      e = predict();
      m_fail = e.exhaust;
      if (e.exhaust) begin
        m_fail_id          = retry_id_i;
        m_busy[retry_id_i] = 0;
        m_cnt[retry_id_i]  = 0;
      end
      if (e.retry_hs) m_cnt[retry_id_i]++;
      if (e.new_hs) begin
        m_busy[e.id] = 1;
        m_cnt[e.id]  = 0;
        m_data[e.id] = data_i;
      end
      if (e.done_free) begin
        m_busy[done_id_i] = 0;
        m_cnt[done_id_i]  = 0;
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (checking) begin
      e = predict();
      chk("valid_o", 32'(valid_o), 32'(e.valid));
      chk("ready_o", 32'(ready_o), 32'(e.ready));
      chk("retry_ready_o", 32'(retry_ready_o), 32'(e.rready));
      chk("busy_o", 32'(busy_o), 32'(model_busy()));
      chk("fail_valid_o", 32'(fail_valid_o), 32'(m_fail));
      if (e.valid) begin
        chk("data_o", 32'(data_o), 32'(e.data));
        chk("id_o", 32'(id_o), 32'(e.id));
      end
      if (m_fail) chk("fail_id_o", 32'(fail_id_o), 32'(m_fail_id));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checking = 1;
    settle();
    chk("reset busy_o", 32'(busy_o), 32'h0);
    chk("reset fail_valid_o", 32'(fail_valid_o), 32'h0);
    chk("reset fail_id_o", 32'(fail_id_o), 32'h0);
    $display("txn reset done");

    // Allocation order: A..D get IDs 0..3
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = 8'hA0 + 8'(i);
      settle();
      chk("alloc id_o", 32'(id_o), 32'(i));
      chk("alloc ready_o", 32'(ready_o), 32'h1);
      $display("txn alloc data=%02h id=%0d", data_i, id_o);
      tick();
    end
    data_i = 8'hAF;
    settle();
    chk("full busy_o", 32'(busy_o), 32'hF);
    chk("full ready_o", 32'(ready_o), 32'h0);
    chk("full valid_o", 32'(valid_o), 32'h0);
    $display("txn fifth op blocked busy=%b", busy_o);
    tick();

    // Free ID 2 and reuse it
    valid_i      = 1'b0;
    done_valid_i = 1'b1;
    done_id_i    = 2'd2;
    tick();
    done_valid_i = 1'b0;
    valid_i      = 1'b1;
    data_i       = 8'hE2;
    settle();
    chk("reuse busy_o", 32'(busy_o), 32'hB);
    chk("reuse id_o", 32'(id_o), 32'h2);
    chk("reuse data_o", 32'(data_o), 32'hE2);
    $display("txn reuse id=%0d data=%02h", id_o, data_o);
    tick();

    // Retry priority: free ID 3, then a retry of ID 1 beats a new op
    valid_i      = 1'b0;
    done_valid_i = 1'b1;
    done_id_i    = 2'd3;
    tick();
    done_valid_i  = 1'b0;
    valid_i       = 1'b1;
    data_i        = 8'h55;
    retry_valid_i = 1'b1;
    retry_id_i    = 2'd1;
    settle();
    chk("prio data_o", 32'(data_o), 32'hA1);
    chk("prio id_o", 32'(id_o), 32'h1);
    chk("prio ready_o", 32'(ready_o), 32'h0);
    chk("prio valid_o", 32'(valid_o), 32'h1);
    $display("txn retry over new id=%0d data=%02h", id_o, data_o);
    tick();
    retry_valid_i = 1'b0;
    settle();
    chk("after prio id_o", 32'(id_o), 32'h3);
    chk("after prio ready_o", 32'(ready_o), 32'h1);
    $display("txn deferred new op id=%0d", id_o);
    tick();
    valid_i = 1'b0;

    // Budget exhaustion on ID 0
    retry_valid_i = 1'b1;
    retry_id_i    = 2'd0;
    for (int r = 0; r < 3; r++) begin
      settle();
      chk("budget valid_o", 32'(valid_o), 32'h1);
      chk("budget data_o", 32'(data_o), 32'hA0);
      $display("txn retry id=0 attempt=%0d", r + 1);
      tick();
    end
    settle();
    chk("exhaust valid_o", 32'(valid_o), 32'h0);
    chk("exhaust retry_ready_o", 32'(retry_ready_o), 32'h1);
    tick();
    retry_valid_i = 1'b0;
    settle();
    chk("exhaust fail_valid_o", 32'(fail_valid_o), 32'h1);
    chk("exhaust fail_id_o", 32'(fail_id_o), 32'h0);
    chk("exhaust busy0", 32'(busy_o[0]), 32'h0);
    $display("txn fail id=%0d", fail_id_o);
    tick();
    chk("pulse width", 32'(fail_valid_o), 32'h0);

    // Backpressure on a retry of ID 2
    retry_valid_i = 1'b1;
    retry_id_i    = 2'd2;
    ready_i       = 1'b0;
    for (int r = 0; r < 5; r++) begin
      settle();
      chk("bp valid_o", 32'(valid_o), 32'h1);
      chk("bp retry_ready_o", 32'(retry_ready_o), 32'h0);
      tick();
    end
    ready_i = 1'b1;
    settle();
    chk("bp release retry_ready_o", 32'(retry_ready_o), 32'h1);
    chk("bp release data_o", 32'(data_o), 32'hE2);
    $display("txn retry id=2 accepted after backpressure");
    tick();
    // Two more retries reach the budget; the next request must be refused.
    tick();
    tick();
    settle();
    chk("bp count exhaust valid_o", 32'(valid_o), 32'h0);
    tick();
    retry_valid_i = 1'b0;
    settle();
    chk("bp fail_valid_o", 32'(fail_valid_o), 32'h1);
    chk("bp fail_id_o", 32'(fail_id_o), 32'h2);
    $display("txn fail id=%0d", fail_id_o);
    tick();

    // Done and retry on the same ID: done wins, no fail
    retry_valid_i = 1'b1;
    retry_id_i    = 2'd1;
    done_valid_i  = 1'b1;
    done_id_i     = 2'd1;
    settle();
    chk("done+retry valid_o", 32'(valid_o), 32'h0);
    chk("done+retry retry_ready_o", 32'(retry_ready_o), 32'h1);
    tick();
    retry_valid_i = 1'b0;
    done_valid_i  = 1'b0;
    settle();
    chk("done+retry fail_valid_o", 32'(fail_valid_o), 32'h0);
    chk("done+retry busy_o", 32'(busy_o), 32'h8);
    $display("txn done beats retry busy=%b", busy_o);

    // Done frees ID 0 while a new op allocates from the pre-edge vector
    valid_i = 1'b1;
    data_i  = 8'h30;
    tick();
    data_i       = 8'h31;
    done_valid_i = 1'b1;
    done_id_i    = 2'd0;
    settle();
    chk("done+alloc id_o", 32'(id_o), 32'h1);
    tick();
    done_valid_i = 1'b0;
    data_i       = 8'h32;
    settle();
    chk("done+alloc next id_o", 32'(id_o), 32'h0);
    $display("txn freed id reused next cycle id=%0d", id_o);
    tick();
    valid_i = 1'b0;

    // Retry of an idle ID is consumed and ignored
    retry_valid_i = 1'b1;
    retry_id_i    = 2'd2;
    settle();
    chk("idle retry retry_ready_o", 32'(retry_ready_o), 32'h1);
    chk("idle retry valid_o", 32'(valid_o), 32'h0);
    tick();
    retry_valid_i = 1'b0;
    settle();
    chk("idle retry fail_valid_o", 32'(fail_valid_o), 32'h0);

    // Reset mid-flight with three IDs busy
    chk("pre-reset busy_o", 32'(busy_o), 32'hB);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    chk("mid reset busy_o", 32'(busy_o), 32'h0);
    chk("mid reset fail_valid_o", 32'(fail_valid_o), 32'h0);
    done_valid_i = 1'b1;
    done_id_i    = 2'd1;
    valid_i      = 1'b1;
    data_i       = 8'h77;
    settle();
    chk("post reset id_o", 32'(id_o), 32'h0);
    tick();
    done_valid_i = 1'b0;
    valid_i      = 1'b0;
    settle();
    chk("post reset busy_o", 32'(busy_o), 32'h1);
    $display("txn reset mid-flight busy=%b", busy_o);
    tick();

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
